// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder standing in for the audio codec control port.
// Frames are {DEV_ADDR,W}, {reg[6:0],data[8]}, data[7:0]; committed writes land in a 16x9 register file.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 16,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
    } state_t;

    state_t     state, state_n;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] bit_cnt;
    logic       byte_full;
    logic [7:0] shreg;
    logic [7:0] byte1;
    logic       bits_clr, shift_en, load_b1, commit, sda_oe;
    logic [8:0] regs [16];

    // Synchronisers reset to the idle-bus level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], I2C_SCLK};
            sda_sync <= {sda_sync[0], I2C_SDAT};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl_rise  =  scl_sync[1] & ~scl_prev;
    assign scl_fall  = ~scl_sync[1] &  scl_prev;
    assign start_det =  scl_sync[1] &  sda_prev & ~sda_sync[1];
    assign stop_det  =  scl_sync[1] & ~sda_prev &  sda_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Bus conditions take priority over bit handling, so a START/STOP edge never shifts data.
    always_comb begin
        state_n  = state;
        bits_clr = 1'b0;
        shift_en = 1'b0;
        load_b1  = 1'b0;
        commit   = 1'b0;
        if (start_det) begin
            state_n  = ADDR;
            bits_clr = 1'b1;
        end else if (stop_det) begin
            state_n = IDLE;
        end else begin
            case (state)
                ADDR: begin
                    shift_en = scl_rise;
                    if (scl_fall && byte_full) begin
                        state_n  = (shreg == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                        bits_clr = 1'b1;
                    end
                end
                ACK_A:  if (scl_fall) state_n = BYTE1;
                BYTE1: begin
                    shift_en = scl_rise;
                    if (scl_fall && byte_full) begin
                        state_n  = ACK_1;
                        bits_clr = 1'b1;
                        load_b1  = 1'b1;
                    end
                end
                ACK_1:  if (scl_fall) state_n = BYTE2;
                BYTE2: begin
                    shift_en = scl_rise;
                    if (scl_fall && byte_full) begin
                        state_n  = ACK_2;
                        bits_clr = 1'b1;
                        commit   = 1'b1;
                    end
                end
                ACK_2:  if (scl_fall) state_n = IGNORE;
                default: state_n = state;
            endcase
        end
    end

    // byte_full marks that eight bits have arrived, since the 3-bit counter wraps back to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
            shreg     <= 8'h00;
            byte1     <= 8'h00;
            wr_valid  <= 1'b0;
            wr_addr   <= 7'h00;
            wr_data   <= 9'h000;
            frame_cnt <= 8'h00;
        end else begin
            wr_valid <= commit;
            if (bits_clr) begin
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
            end else if (shift_en) begin
                shreg   <= {shreg[6:0], sda_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end
            if (load_b1) byte1 <= shreg;
            if (commit) begin
                wr_addr <= byte1[7:1];
                wr_data <= {byte1[0], shreg};
                if (frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 9'h000;
        end else if (commit) begin
            if (byte1[7:1] == RESET_REG) begin
                for (int i = 0; i < 16; i++) regs[i] <= 9'h000;
            end else if (int'(byte1[7:1]) < NUM_REGS) begin
                regs[byte1[4:1]] <= {byte1[0], shreg};
            end
        end
    end

    assign sda_oe   = (state == ACK_A) || (state == ACK_1) || (state == ACK_2);
    assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
    assign busy     = (state != IDLE);
    assign rd_data  = regs[rd_addr];

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master plus a frame-level register model.
module tb_i2c_codec_responder;

    localparam int Q = 6;
    localparam int H = 12;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       scl_m   = 1'b1;
    logic       sda_m   = 1'b1;
    logic [3:0] rd_addr = 4'h0;
    wire        sda;
    logic [8:0] rd_data;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic [7:0] frame_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0] model_regs [16];
    int         model_cnt = 0;
    int         exp_wv    = 0;
    logic [6:0] exp_addr  = 7'h00;
    logic [8:0] exp_data  = 9'h000;
    int         wv_count  = 0;
    logic [6:0] mon_addr  = 7'h00;
    logic [8:0] mon_data  = 9'h000;

    assign sda = sda_m ? 1'bz : 1'b0;
    pullup sda_pu (sda);

    i2c_codec_responder dut (
        .clk       (clk),
        .reset     (reset),
        .I2C_SCLK  (scl_m),
        .I2C_SDAT  (sda),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Every high clk of wr_valid counts as one commit, so a stretched pulse shows up as extra writes.
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            wv_count = wv_count + 1;
            mon_addr = wr_addr;
            mon_data = wr_data;
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < 16; i++) model_regs[i] = 9'h000;
    endtask

    task automatic modelCommit(input logic [7:0] b1, input logic [7:0] b2);
        logic [6:0] r;
        logic [8:0] d;
        r = b1[7:1];
        d = {b1[0], b2};
        if (r == 7'h0F) modelClear();
        else if (r < 7'd16) model_regs[r[3:0]] = d;
        if (model_cnt < 255) model_cnt = model_cnt + 1;
        exp_wv   = exp_wv + 1;
        exp_addr = r;
        exp_data = d;
    endtask

    task automatic i2cStart();
        sda_m = 1'b1; waitClk(Q);
        scl_m = 1'b1; waitClk(Q);
        sda_m = 1'b0; waitClk(Q);
        scl_m = 1'b0; waitClk(Q);
    endtask

    task automatic i2cStop();
        sda_m = 1'b0; waitClk(Q);
        scl_m = 1'b1; waitClk(Q);
        sda_m = 1'b1; waitClk(Q);
    endtask

    task automatic sendBit(input logic b);
        sda_m = b;    waitClk(Q);
        scl_m = 1'b1; waitClk(H);
        scl_m = 1'b0; waitClk(Q);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic acked;
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        sda_m = 1'b1; waitClk(Q);
        scl_m = 1'b1; waitClk(H / 2);
        @(negedge clk);
        acked = (sda === 1'b0);
        checkOutput(tag, 32'(acked), 32'(exp_ack));
        waitClk(H / 2);
        scl_m = 1'b0; waitClk(Q);
    endtask

    // One complete transaction: START, n bytes, STOP; ACKs and the commit come from the frame rules.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b1, input logic [7:0] b2,
                                 input logic [7:0] b3, input int n, input string tag);
        logic [7:0] bs [4];
        bs = '{a, b1, b2, b3};
        i2cStart();
        for (int k = 0; k < n; k++) sendByte(bs[k], (a == 8'h34) && (k < 3), tag);
        i2cStop();
        waitClk(4);
        if ((a == 8'h34) && (n >= 3)) modelCommit(b1, b2);
    endtask

    task automatic checkState(input string tag);
        @(negedge clk);
        checkOutput({tag, "_wvcount"}, 32'(wv_count), 32'(exp_wv));
        checkOutput({tag, "_framecnt"}, 32'(frame_cnt), 32'(model_cnt));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        if (exp_wv > 0) begin
            checkOutput({tag, "_wraddr"}, 32'(mon_addr), 32'(exp_addr));
            checkOutput({tag, "_wrdata"}, 32'(mon_data), 32'(exp_data));
        end
    endtask

    task automatic checkReg(input int idx, input logic [8:0] exp, input string tag);
        @(negedge clk);
        rd_addr = 4'(idx);
        #1;
        checkOutput($sformatf("%s_reg%0d", tag, idx), 32'(rd_data), 32'(exp));
    endtask

    task automatic checkRegs(input string tag);
        for (int i = 0; i < 16; i++) checkReg(i, model_regs[i], tag);
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        waitClk(3);
        modelClear();
        model_cnt = 0;
        reset = 1'b1;
        waitClk(3);
    endtask

    initial begin
        logic [8:0] init_data [10];
        logic [8:0] d;
        logic [6:0] r;
        logic [7:0] a;
        int         n, kind;
        init_data = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h015, 9'h000, 9'h000, 9'h042, 9'h019, 9'h001};
        modelClear();

        waitClk(3);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wrvalid", 32'(wr_valid), 32'd0);
        checkOutput("rst_framecnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_wraddr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wrdata", 32'(wr_data), 32'd0);
        checkOutput("rst_sda", 32'(sda !== 1'b0), 32'd1);
        checkRegs("rst");
        reset = 1'b1;
        waitClk(4);

        $display("[TB] T1 basic frame");
        applyStimulus(8'h34, 8'h0E, 8'h42, 8'h00, 3, "t1_ack");
        checkState("t1");
        checkReg(7, 9'h042, "t1");
        checkOutput("t1_framecnt_const", 32'(frame_cnt), 32'd1);

        $display("[TB] T2 foreign address");
        i2cStart();
        sendByte(8'h36, 1'b0, "t2_ack");
        @(negedge clk);
        checkOutput("t2_busy_mid", 32'(busy), 32'd1);
        sendByte(8'h0E, 1'b0, "t2_ack");
        sendByte(8'h42, 1'b0, "t2_ack");
        i2cStop();
        waitClk(4);
        checkState("t2");

        $display("[TB] T3 write then register-file clear");
        applyStimulus(8'h34, 8'h08, 8'h15, 8'h00, 3, "t3_ack");
        checkReg(4, 9'h015, "t3a");
        applyStimulus(8'h34, 8'h1E, 8'h00, 8'h00, 3, "t3_ack");
        checkState("t3");
        checkRegs("t3");
        checkOutput("t3_framecnt_const", 32'(frame_cnt), 32'd3);

        $display("[TB] T4 truncated frame and repeated START");
        applyStimulus(8'h34, 8'h0E, 8'h00, 8'h00, 2, "t4_ack");
        checkState("t4a");
        checkReg(7, model_regs[7], "t4a");
        i2cStart();
        sendByte(8'h34, 1'b1, "t4_ack");
        sendByte(8'h0E, 1'b1, "t4_ack");
        i2cStart();
        sendByte(8'h34, 1'b1, "t4_ack");
        sendByte(8'h01, 1'b1, "t4_ack");
        sendByte(8'h97, 1'b1, "t4_ack");
        i2cStop();
        waitClk(4);
        modelCommit(8'h01, 8'h97);
        checkState("t4b");
        checkReg(0, 9'h197, "t4b");
        checkReg(7, model_regs[7], "t4b");

        $display("[TB] T5 reset during BYTE2");
        i2cStart();
        sendByte(8'h34, 1'b1, "t5_ack");
        sendByte(8'h12, 1'b1, "t5_ack");
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        sda_m = 1'b0; waitClk(Q);
        scl_m = 1'b1; waitClk(H / 2);
        reset = 1'b0;
        sda_m = 1'b1;
        @(negedge clk);
        checkOutput("t5_sda", 32'(sda !== 1'b0), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        modelClear();
        model_cnt = 0;
        waitClk(4);
        reset = 1'b1;
        waitClk(4);
        checkState("t5a");
        applyStimulus(8'h34, 8'h12, 8'h01, 8'h00, 3, "t5_ack");
        checkState("t5b");
        checkReg(9, 9'h001, "t5b");

        $display("[TB] T6 initialise sequence");
        pulseReset();
        for (int i = 0; i < 10; i++) begin
            d = init_data[i];
            applyStimulus(8'h34, {7'(i), d[8]}, d[7:0], 8'h00, 3, "t6_ack");
        end
        checkState("t6");
        checkOutput("t6_framecnt_const", 32'(frame_cnt), 32'd10);
        for (int i = 0; i < 10; i++) checkReg(i, init_data[i], "t6");

        $display("[TB] random frames");
        for (int f = 0; f < 16; f++) begin
            kind = int'($urandom_range(0, 9));
            r    = 7'($urandom_range(0, 20));
            d    = 9'($urandom);
            a    = (kind == 0) ? 8'h36 : 8'h34;
            n    = (kind == 1) ? 2 : (kind == 2) ? 4 : 3;
            applyStimulus(a, {r, d[8]}, d[7:0], 8'($urandom), n, "rnd_ack");
            checkState("rnd");
        end
        checkRegs("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
